axi_burst_mem_slave: RTL and testbench

// Synthesisable AXI4 burst memory slave on the passthrough VIP's master-side bus inside chip.

---
 rtl/axi_burst_mem_pkg.sv | 42 ++++
 rtl/axi_burst_mem_ram.sv | 34 +++
 rtl/axi_burst_mem_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_mem_pkg.sv
// Shared burst/response encodings, FSM states and burst address stepping.
// Latency: n/a (pure types and functions).
// Backpressure: n/a.
package axi_burst_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_DATA
    } state_t;

    // Reserved encoding, or a WRAP whose length is not a power-of-two block of 2..16 beats.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        logic len_ok;
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((burst == BURST_WRAP) && !len_ok);
    endfunction

    // Word address of the following beat; a bad burst steps like INCR.
    function automatic logic [31:0] next_word(input logic [31:0] word,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] mask;
        mask = {24'd0, len};
        if (burst == BURST_FIXED) begin
            return word;
        end
        if ((burst == BURST_WRAP) && !burst_bad(burst, len)) begin
            return (word & ~mask) | ((word + 32'd1) & mask);
        end
        return word + 32'd1;
    endfunction

endpackage

// File: rtl/axi_burst_mem_ram.sv
// Single-clock RAM, byte-enable write port and registered read port; contents are never reset.
// Latency: read data valid the cycle after re_i.
// Backpressure: none; rdata_o holds while re_i is low.
module axi_burst_mem_ram #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    localparam int IW       = $clog2(MEM_WORDS)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [IW-1:0]       waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    input  logic [IW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be_i[b]) begin
                    mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: one write or read burst at a time into byte-writable RAM.
// Latency: bvalid 1 cycle after last W beat; first rvalid 2 cycles after AR handshake, then 1 beat/cycle.
// Backpressure: rready low freezes the R stage and the prefetch behind it; bvalid holds until bready.
module axi_burst_mem_slave
    import axi_burst_mem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam int WA  = ADDR_W - OFF;
    localparam int IW  = $clog2(MEM_WORDS);

    state_t            state_q, state_d;
    logic              prio_wr_q, prio_wr_d;
    logic [WA-1:0]     word_q, word_d;
    logic [7:0]        len_q, len_d, cnt_q, cnt_d;
    logic [1:0]        burst_q, burst_d;
    logic              bad_q, bad_d, err_q, err_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              s1_vld_q, s1_vld_d, s1_oor_q, s1_oor_d, s1_last_q, s1_last_d;
    logic              iss_done_q, iss_done_d;
    logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, ram_rdata;

    logic          grant_wr, word_oor, beat_last, out_adv, issue, ram_we;
    logic [WA-1:0] nxt_word;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

    assign grant_wr      = s_axi_awvalid && (!s_axi_arvalid || prio_wr_q);
    assign s_axi_awready = (state_q == ST_IDLE) && grant_wr;
    assign s_axi_arready = (state_q == ST_IDLE) && s_axi_arvalid && !grant_wr;
    assign s_axi_wready  = (state_q == ST_WR_DATA);

    assign word_oor  = 32'(word_q) >= MEM_WORDS;
    assign beat_last = (cnt_q == len_q);
    assign nxt_word  = WA'(next_word(32'(word_q), len_q, burst_q));
    // RAM output acts as a one-entry prefetch stage in front of the R register.
    assign out_adv   = !rvalid_q || s_axi_rready;
    assign issue     = (state_q == ST_RD_DATA) && !iss_done_q && (!s1_vld_q || out_adv);

    always_comb begin
        state_d    = state_q;
        prio_wr_d  = prio_wr_q;
        word_d     = word_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        bad_d      = bad_q;
        err_d      = err_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        s1_vld_d   = s1_vld_q;
        s1_oor_d   = s1_oor_q;
        s1_last_d  = s1_last_q;
        iss_done_d = iss_done_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    state_d   = ST_WR_DATA;
                    prio_wr_d = 1'b0;
                    word_d    = s_axi_awaddr[ADDR_W-1:OFF];
                    len_d     = s_axi_awlen;
                    burst_d   = s_axi_awburst;
                    bad_d     = burst_bad(s_axi_awburst, s_axi_awlen);
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                end else if (s_axi_arvalid && s_axi_arready) begin
                    state_d    = ST_RD_DATA;
                    prio_wr_d  = 1'b1;
                    word_d     = s_axi_araddr[ADDR_W-1:OFF];
                    len_d      = s_axi_arlen;
                    burst_d    = s_axi_arburst;
                    bad_d      = burst_bad(s_axi_arburst, s_axi_arlen);
                    cnt_d      = 8'd0;
                    iss_done_d = 1'b0;
                end
            end
            ST_WR_DATA: begin
                if (s_axi_wvalid) begin
                    ram_we = !word_oor;
                    word_d = nxt_word;
                    cnt_d  = cnt_q + 8'd1;
                    if (beat_last) begin
                        state_d  = ST_WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || bad_q || word_oor || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                    end else if (word_oor || s_axi_wlast) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                if (rvalid_q && s_axi_rready && rlast_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (issue) begin
            s1_vld_d  = 1'b1;
            s1_oor_d  = word_oor;
            s1_last_d = beat_last;
            word_d    = nxt_word;
            cnt_d     = cnt_q + 8'd1;
            if (beat_last) begin
                iss_done_d = 1'b1;
            end
        end else if (out_adv) begin
            s1_vld_d = 1'b0;
        end

        if (out_adv) begin
            rvalid_d = s1_vld_q;
            if (s1_vld_q) begin
                rdata_d = s1_oor_q ? '0 : ram_rdata;
                rresp_d = (s1_oor_q || bad_q) ? RESP_SLVERR : RESP_OKAY;
                rlast_d = s1_last_q;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            prio_wr_q  <= 1'b1;
            word_q     <= '0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            burst_q    <= 2'b00;
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            s1_vld_q   <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            iss_done_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_wr_q  <= prio_wr_d;
            word_q     <= word_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            s1_vld_q   <= s1_vld_d;
            s1_oor_q   <= s1_oor_d;
            s1_last_q  <= s1_last_d;
            iss_done_q <= iss_done_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    axi_burst_mem_ram #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (ram_we),
        .be_i    (s_axi_wstrb),
        .waddr_i (word_q[IW-1:0]),
        .wdata_i (s_axi_wdata),
        .re_i    (issue),
        .raddr_i (word_q[IW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboarded bench for axi_burst_mem_slave: directed bursts, expected responses queued at issue.
// RAM is shrunk to 256 words so byte address 0x400 is out of range and aliases word 0 if wrongly written.
module tb_axi_burst_mem_slave;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 256;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY  = 2'b00, SLVERR = 2'b10;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]        s_axi_awlen = '0, s_axi_arlen = '0;
    logic [1:0]        s_axi_awburst = '0, s_axi_arburst = '0;
    logic              s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic              s_axi_awready, s_axi_arready;
    logic [DATA_W-1:0] s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]        s_axi_bresp, s_axi_rresp;
    logic              s_axi_bvalid, s_axi_bready = 1'b1;
    logic [DATA_W-1:0] s_axi_rdata;
    logic              s_axi_rlast, s_axi_rvalid, s_axi_rready;

    always #5 aclk = ~aclk;

    axi_burst_mem_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    bit          exp_g[$];     // 0 = write grant, 1 = read grant
    int          checks = 0;
    int          failures = 0;
    int          timeouts = 0;
    bit          done = 1'b0;
    bit          rr_toggle = 1'b0;
    logic [31:0] wbeats [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: the only process that steps checks/failures.
    initial begin : monitor
        rbeat_t     a, e, hold;
        logic [1:0] eb;
        bit         hold_vld;
        int         cyc;
        hold_vld = 1'b0;
        hold     = '0;
        cyc      = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                chk("reset_outputs",
                    64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
                         s_axi_bresp, s_axi_rresp, s_axi_rlast, s_axi_rdata}), 64'd0);
                hold_vld = 1'b0;
            end else begin
                a = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
                if (hold_vld && s_axi_rvalid) begin
                    chk("r_stall_stable", 64'(a), 64'(hold));
                end
                hold_vld = s_axi_rvalid && !s_axi_rready;
                hold     = a;
                if (s_axi_awvalid && s_axi_awready) begin
                    if (exp_g.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL aw_grant actual=granted required=no_grant");
                    end else begin
                        chk("grant_order_aw", 64'(1'b0), 64'(exp_g.pop_front()));
                    end
                end
                if (s_axi_arvalid && s_axi_arready) begin
                    if (exp_g.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL ar_grant actual=granted required=no_grant");
                    end else begin
                        chk("grant_order_ar", 64'(1'b1), 64'(exp_g.pop_front()));
                    end
                end
                if (s_axi_bvalid && s_axi_bready) begin
                    if (exp_b.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_resp actual=%0h required=no_response", s_axi_bresp);
                    end else begin
                        eb = exp_b.pop_front();
                        chk("bresp", 64'(s_axi_bresp), 64'(eb));
                    end
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (exp_r.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL r_beat actual=%0h required=no_beat", a);
                    end else begin
                        e = exp_r.pop_front();
                        chk("r_beat{data,resp,last}", 64'(a), 64'(e));
                    end
                end
            end
            if (done || cyc > 60000) begin
                if (!done) begin
                    checks++; failures++;
                    $display("FAIL global_watchdog actual=%0d_cycles required=done", cyc);
                end
                chk("bench_timeouts", 64'(timeouts), 64'd0);
                chk("r_drained", 64'(exp_r.size()), 64'd0);
                chk("b_drained", 64'(exp_b.size()), 64'd0);
                chk("grants_drained", 64'(exp_g.size()), 64'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin : rready_drv
        s_axi_rready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            s_axi_rready = rr_toggle ? ~s_axi_rready : 1'b1;
        end
    end

    task automatic exp_rd(input logic [31:0] d, input logic [1:0] r, input logic l);
        exp_r.push_back({d, r, l});
    endtask

    task automatic drive_ar(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 200);
        if (!s_axi_arready) begin timeouts++; $display("timeout: arready"); end
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic read_burst(input logic [11:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit push_g);
        int n;
        if (push_g) exp_g.push_back(1'b1);
        drive_ar(addr, len, burst);
        n = 0;
        do begin @(negedge aclk); n++; end
        while (!(s_axi_rvalid && s_axi_rready && s_axi_rlast) && n < 3000);
        if (!(s_axi_rvalid && s_axi_rready && s_axi_rlast)) begin
            timeouts++; $display("timeout: rlast");
        end
        @(posedge aclk); #1;
    endtask

    task automatic write_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [3:0] strb, input int wl, input logic [1:0] resp,
                               input bit push_g);
        int n;
        exp_b.push_back(resp);
        if (push_g) exp_g.push_back(1'b0);
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_awready && n < 200);
        if (!s_axi_awready) begin timeouts++; $display("timeout: awready"); end
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wbeats[i];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == wl);
            n = 0;
            do begin @(negedge aclk); n++; end while (!s_axi_wready && n < 200);
            if (!s_axi_wready) begin timeouts++; $display("timeout: wready"); end
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_bvalid && n < 200);
        if (!s_axi_bvalid) begin timeouts++; $display("timeout: bvalid"); end
        @(posedge aclk); #1;
    endtask

    task automatic write1(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] strb,
                          input logic [1:0] resp);
        wbeats[0] = d;
        write_burst(addr, 8'd0, INCR, strb, 0, resp, 1'b1);
    endtask

    initial begin : stim
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Full 256-beat INCR burst covers the whole RAM and the counter top end.
        for (int i = 0; i < 256; i++) wbeats[i] = 32'h1000 + i;
        write_burst(12'h000, 8'd255, INCR, 4'hF, 255, OKAY, 1'b1);
        for (int i = 0; i < 256; i++) exp_rd(32'h1000 + i, OKAY, i == 255);
        read_burst(12'h000, 8'd255, INCR, 1'b1);

        // Out-of-range word 256 must not alias onto word 0.
        write1(12'h400, 32'h5555_5555, 4'hF, SLVERR);
        exp_rd(32'h0000_1000, OKAY, 1'b1);
        read_burst(12'h000, 8'd0, INCR, 1'b1);
        exp_rd(32'h0, SLVERR, 1'b1);
        read_burst(12'h400, 8'd0, INCR, 1'b1);

        // INCR read crossing the top of the RAM.
        write1(12'h3FC, 32'hCAFE_F00D, 4'hF, OKAY);
        exp_rd(32'hCAFE_F00D, OKAY, 1'b0);
        exp_rd(32'h0, SLVERR, 1'b1);
        read_burst(12'h3FC, 8'd1, INCR, 1'b1);

        for (int i = 0; i < 4; i++) wbeats[i] = 32'hA0 + i;
        write_burst(12'h100, 8'd3, INCR, 4'hF, 3, OKAY, 1'b1);
        for (int i = 0; i < 4; i++) exp_rd(32'hA0 + i, OKAY, i == 3);
        read_burst(12'h100, 8'd3, INCR, 1'b1);

        // WRAP @0x108 lands on 0x108,0x10C,0x100,0x104.
        for (int i = 0; i < 4; i++) wbeats[i] = 32'hB0 + i;
        write_burst(12'h108, 8'd3, WRAP, 4'hF, 3, OKAY, 1'b1);
        for (int i = 0; i < 4; i++) exp_rd(32'hB0 + i, OKAY, i == 3);
        read_burst(12'h108, 8'd3, WRAP, 1'b1);
        exp_rd(32'hB2, OKAY, 1'b0); exp_rd(32'hB3, OKAY, 1'b0);
        exp_rd(32'hB0, OKAY, 1'b0); exp_rd(32'hB1, OKAY, 1'b1);
        read_burst(12'h100, 8'd3, INCR, 1'b1);

        write1(12'h200, 32'h1111_1111, 4'hF, OKAY);
        write1(12'h200, 32'hDEAD_BEEF, 4'h3, OKAY);
        exp_rd(32'h1111_BEEF, OKAY, 1'b0);
        exp_rd(32'h1111_BEEF, OKAY, 1'b0);
        exp_rd(32'h1111_BEEF, OKAY, 1'b1);
        read_burst(12'h200, 8'd2, FIXED, 1'b1);

        for (int i = 0; i < 4; i++) wbeats[i] = 32'hE0 + i;
        write_burst(12'h300, 8'd3, INCR, 4'hF, 1, SLVERR, 1'b1);
        write_burst(12'h300, 8'd3, INCR, 4'hF, 9, SLVERR, 1'b1);
        write_burst(12'h310, 8'd2, WRAP, 4'hF, 2, SLVERR, 1'b1);
        exp_rd(32'hB2, SLVERR, 1'b0);
        exp_rd(32'hB3, SLVERR, 1'b1);
        read_burst(12'h100, 8'd1, RSVD, 1'b1);

        // Last grant was a read, so the first simultaneous pair goes write-first.
        exp_g.push_back(1'b0);
        exp_g.push_back(1'b1);
        exp_rd(32'hB2, OKAY, 1'b1);
        wbeats[0] = 32'h77;
        fork
            write_burst(12'h040, 8'd0, INCR, 4'hF, 0, OKAY, 1'b0);
            read_burst(12'h100, 8'd0, INCR, 1'b0);
        join
        write1(12'h044, 32'h88, 4'hF, OKAY);
        // Last grant was a write, so this pair goes read-first and sees the old 0x77.
        exp_g.push_back(1'b1);
        exp_g.push_back(1'b0);
        exp_rd(32'h77, OKAY, 1'b1);
        wbeats[0] = 32'h99;
        fork
            write_burst(12'h040, 8'd0, INCR, 4'hF, 0, OKAY, 1'b0);
            read_burst(12'h040, 8'd0, INCR, 1'b0);
        join
        exp_rd(32'h99, OKAY, 1'b1);
        read_burst(12'h040, 8'd0, INCR, 1'b1);

        for (int i = 0; i < 8; i++) wbeats[i] = 32'hC0 + i;
        write_burst(12'h180, 8'd7, INCR, 4'hF, 7, OKAY, 1'b1);
        rr_toggle = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd(32'hC0 + i, OKAY, i == 7);
        read_burst(12'h180, 8'd7, INCR, 1'b1);
        rr_toggle = 1'b0;
        @(posedge aclk); #1;

        // Reset mid-read: remaining beats are abandoned.
        for (int i = 0; i < 8; i++) exp_rd(32'hC0 + i, OKAY, i == 7);
        exp_g.push_back(1'b1);
        drive_ar(12'h180, 8'd7, INCR);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b0;
        @(posedge aclk); #1;
        exp_r.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        exp_rd(32'hC0, OKAY, 1'b1);
        read_burst(12'h180, 8'd0, INCR, 1'b1);
        write1(12'h184, 32'h1234_5678, 4'hF, OKAY);
        exp_rd(32'h1234_5678, OKAY, 1'b0);
        exp_rd(32'hC2, OKAY, 1'b1);
        read_burst(12'h184, 8'd1, INCR, 1'b1);

        repeat (2) @(posedge aclk);
        done = 1'b1;
    end

endmodule
